ps2_scancode_decoder: RTL and testbench

Sits directly downstream of the PS/2 byte receiver. It consumes each received byte (rx_data qualified by the one-cycle rx_done pulse) and parses Set-2 scancode sequences: E0 extended prefix, F0 break prefix, E1 Pause sequence, and device/status bytes. Each completed sequence becomes one key event in a small first-word-fall-through FIFO that the application logic drains. The block also maintains live Shift/Ctrl held flags.

---
 rtl/ps2_scancode_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Parses PS/2 Set-2 scancode byte streams into key events and queues them
//   in a small first-word-fall-through FIFO. Tracks live Shift/Ctrl state.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   rx_data/rx_done : received byte, qualified by a one-cycle pulse
//   evt_rd          : pop the head event (ignored when empty)
//   evt_valid       : FIFO not empty, head event on evt_code/ext/rel
//   evt_code/ext/rel: head event scancode, E0-prefixed flag, release flag
//   evt_ovf         : one-cycle pulse when an event is dropped on a full FIFO
//   shift_held      : left (12) or right (59) Shift pressed
//   ctrl_held       : left (14) or right (E0 14) Ctrl pressed
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       evt_rd,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       evt_ovf,
  output logic       shift_held,
  output logic       ctrl_held
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_F0 = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } evt_t;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_E1
  } state_t;

  // Device/status bytes that never start or complete a key sequence.
  function automatic logic is_filt(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  state_t        state, nxt;
  logic [2:0]    skip;
  logic [TW-1:0] tcnt;
  logic          emit;
  evt_t          emit_evt;
  logic          filt;

  // ---------------------------------------------------------------------------
  // Sequence decode: next state and event to emit for the byte in this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt      = state;
    emit     = 1'b0;
    emit_evt = {rx_data, 1'b0, 1'b0};
    filt     = is_filt(rx_data);
    if (rx_done) begin
      case (state)
        IDLE: begin
          if (rx_data == B_F0)      nxt = GOT_F0;
          else if (rx_data == B_E0) nxt = GOT_E0;
          else if (rx_data == B_E1) begin
            // Pause is reported once as a bare E1; its tail is swallowed.
            emit = 1'b1;
            nxt  = SKIP_E1;
          end
          else if (!filt)           emit = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == B_F0)      nxt = GOT_E0F0;
          else if (rx_data == B_E0) nxt = GOT_E0;
          else if (filt)            nxt = IDLE;
          else begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            nxt          = IDLE;
          end
        end
        GOT_F0: begin
          nxt = IDLE;
          if (!(rx_data == B_E0 || rx_data == B_F0 || filt)) begin
            emit         = 1'b1;
            emit_evt.rel = 1'b1;
          end
        end
        GOT_E0F0: begin
          nxt = IDLE;
          if (!(rx_data == B_E0 || rx_data == B_F0 || filt)) begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            emit_evt.rel = 1'b1;
          end
        end
        SKIP_E1: nxt = (skip <= 3'd1) ? IDLE : SKIP_E1;
        default: nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Parser state, Pause skip counter and inter-byte timeout.
  // A byte arriving in the timeout cycle takes priority over the abandon.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      skip  <= 3'd0;
      tcnt  <= '0;
    end else if (rx_done) begin
      state <= nxt;
      tcnt  <= '0;
      if (state == IDLE && rx_data == B_E1) skip <= 3'd7;
      else if (state == SKIP_E1)            skip <= skip - 3'd1;
    end else if (state != IDLE) begin
      if (tcnt == TO_LAST) begin
        state <= IDLE;
        skip  <= 3'd0;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end else begin
      tcnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. The head is kept in output registers; head_n is what the head
  // will be after this edge, taking a write into an empty slot into account.
  // ---------------------------------------------------------------------------
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n, remain;
  logic          pop_ok, push_ok;
  evt_t          head_n;

  always_comb begin
    pop_ok   = evt_rd && (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = emit && ((count != FULL_CNT) || pop_ok);
    count_n  = count + CW'(push_ok) - CW'(pop_ok);
    rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    remain   = count - CW'(pop_ok);
    if (push_ok && remain == '0) head_n = emit_evt;
    else                         head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= emit_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_rel   <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      evt_ovf   <= emit && !push_ok;
      // Outputs hold their last value once the FIFO drains.
      if (count_n != '0) {evt_code, evt_ext, evt_rel} <= head_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Modifier tracking, driven by every decoded event whether or not it fits.
  // ---------------------------------------------------------------------------
  logic lshift, rshift, lctrl, rctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      lctrl  <= 1'b0;
      rctrl  <= 1'b0;
    end else if (emit) begin
      if (emit_evt.code == 8'h12 && !emit_evt.ext) lshift <= !emit_evt.rel;
      if (emit_evt.code == 8'h59 && !emit_evt.ext) rshift <= !emit_evt.rel;
      if (emit_evt.code == 8'h14 && !emit_evt.ext) lctrl  <= !emit_evt.rel;
      if (emit_evt.code == 8'h14 &&  emit_evt.ext) rctrl  <= !emit_evt.rel;
    end
  end

  assign shift_held = lshift | rshift;
  assign ctrl_held  = lctrl | rctrl;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//   Directed scenarios plus randomized byte streams, checked against a
//   sequence-level reference model (prefix flags, skip count, event queue).
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       evt_rd;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_rel;
  logic       evt_ovf;
  logic       shift_held;
  logic       ctrl_held;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .evt_rd(evt_rd), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_rel(evt_rel), .evt_ovf(evt_ovf),
    .shift_held(shift_held), .ctrl_held(ctrl_held)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---- reference model ----
  logic [9:0] m_q[$];
  bit m_e0, m_f0, m_ovf;
  int m_skip, m_gap;
  bit m_lsh, m_rsh, m_lct, m_rct;

  function automatic bit filt(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_e0 = 0; m_f0 = 0; m_ovf = 0; m_skip = 0; m_gap = 0;
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0;
  endtask

  task automatic model_emit(input logic [7:0] c, input bit ext, input bit rel);
    if (c == 8'h12 && !ext) m_lsh = !rel;
    if (c == 8'h59 && !ext) m_rsh = !rel;
    if (c == 8'h14 && !ext) m_lct = !rel;
    if (c == 8'h14 &&  ext) m_rct = !rel;
    if (m_q.size() < DEPTH) m_q.push_back({c, ext, rel});
    else m_ovf = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_gap >= TO) begin m_e0 = 0; m_f0 = 0; m_skip = 0; end
    if (m_skip > 0) begin m_skip--; return; end
    if (filt(b)) begin m_e0 = 0; m_f0 = 0; end
    else if (b == 8'hF0) begin
      if (m_f0) begin m_e0 = 0; m_f0 = 0; end else m_f0 = 1;
    end else if (b == 8'hE0) begin
      if (m_f0) begin m_e0 = 0; m_f0 = 0; end else m_e0 = 1;
    end else if (b == 8'hE1 && !m_e0 && !m_f0) begin
      model_emit(b, 0, 0);
      m_skip = 7;
    end else begin
      model_emit(b, m_e0, m_f0);
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input bit rd, input bit dn, input logic [7:0] b);
    rx_done = dn; rx_data = b; evt_rd = rd;
    @(posedge clk);
    m_ovf = 0;
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (dn) begin model_byte(b); m_gap = 0; end
    else m_gap++;
    #1;
    rx_done = 0; evt_rd = 0;
  endtask

  task automatic drain();
    int n;
    n = m_q.size();
    repeat (n) step(1, 0, 8'h00);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 0; rx_done = 0; rx_data = 0; evt_rd = 0;
    #2;
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_rel, evt_ovf, shift_held, ctrl_held} !== 13'h0)
      $display("FAIL reset_outputs: got %h expected 0",
               {evt_valid, evt_code, evt_ext, evt_rel, evt_ovf, shift_held, ctrl_held});
    if ({evt_valid, evt_code, evt_ext, evt_rel, evt_ovf, shift_held, ctrl_held} !== 13'h0) n_fail++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_clear();
  endtask

  task automatic test_make_break();
    logic [9:0] exp [2];
    exp[0] = {8'h1C, 1'b0, 1'b0};
    exp[1] = {8'h1C, 1'b0, 1'b1};
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mb_idle_valid: got %b expected 0", evt_valid); end
    step(0, 1, 8'h1C);
    n_tests++;
    if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mb_latency: valid got %b expected 1", evt_valid); end
    step(0, 1, 8'hF0);
    step(0, 1, 8'h1C);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== exp[i]) begin
        n_fail++;
        $display("FAIL mb_event%0d: got v=%b %h expected v=1 %h", i, evt_valid, {evt_code, evt_ext, evt_rel}, exp[i]);
      end
      step(1, 0, 8'h00);
    end
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mb_empty: valid got %b expected 0", evt_valid); end
    n_tests++;
    if ({evt_code, evt_ext, evt_rel} !== exp[1]) begin
      n_fail++; $display("FAIL mb_hold: got %h expected %h", {evt_code, evt_ext, evt_rel}, exp[1]);
    end
  endtask

  task automatic test_extended();
    logic [9:0] exp [2];
    exp[0] = {8'h75, 1'b1, 1'b0};
    exp[1] = {8'h75, 1'b1, 1'b1};
    step(0, 1, 8'hE0); step(0, 1, 8'h75);
    step(0, 1, 8'hE0); step(0, 1, 8'hF0); step(0, 1, 8'h75);
    repeat (3) step(0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== exp[i]) begin
        n_fail++;
        $display("FAIL ext_event%0d: got v=%b %h expected v=1 %h", i, evt_valid, {evt_code, evt_ext, evt_rel}, exp[i]);
      end
      step(1, 0, 8'h00);
    end
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ext_empty: valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_modifiers();
    step(0, 1, 8'h12);
    n_tests++;
    if (shift_held !== 1'b1) begin n_fail++; $display("FAIL mod_lshift_make: got %b expected 1", shift_held); end
    step(0, 1, 8'h14);
    n_tests++;
    if (ctrl_held !== 1'b1) begin n_fail++; $display("FAIL mod_lctrl_make: got %b expected 1", ctrl_held); end
    step(0, 1, 8'hE0); step(0, 1, 8'h14);
    drain();
    step(0, 1, 8'hF0); step(0, 1, 8'h12);
    n_tests++;
    if (shift_held !== 1'b0) begin n_fail++; $display("FAIL mod_lshift_break: got %b expected 0", shift_held); end
    step(0, 1, 8'hF0); step(0, 1, 8'h14);
    n_tests++;
    if (ctrl_held !== 1'b1) begin n_fail++; $display("FAIL mod_rctrl_holds: got %b expected 1", ctrl_held); end
    step(0, 1, 8'hE0); step(0, 1, 8'hF0); step(0, 1, 8'h14);
    n_tests++;
    if (ctrl_held !== 1'b0) begin n_fail++; $display("FAIL mod_rctrl_break: got %b expected 0", ctrl_held); end
    drain();
    step(0, 1, 8'h59); step(0, 1, 8'h59);
    n_tests++;
    if (shift_held !== 1'b1) begin n_fail++; $display("FAIL mod_rshift_repeat: got %b expected 1", shift_held); end
    step(0, 1, 8'hF0); step(0, 1, 8'h59);
    n_tests++;
    if (shift_held !== 1'b0) begin n_fail++; $display("FAIL mod_rshift_break: got %b expected 0", shift_held); end
    drain();
  endtask

  task automatic test_pause_filter();
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    for (int i = 0; i < 9; i++) step(0, 1, seq[i]);
    n_tests++;
    if (ctrl_held !== 1'b0) begin n_fail++; $display("FAIL pause_ctrl: got %b expected 0", ctrl_held); end
    n_tests++;
    if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== {8'hE1, 2'b00}) begin
      n_fail++; $display("FAIL pause_e1: got v=%b %h expected v=1 384", evt_valid, {evt_code, evt_ext, evt_rel});
    end
    step(1, 0, 8'h00);
    n_tests++;
    if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("FAIL pause_next: got v=%b %h expected v=1 070", evt_valid, {evt_code, evt_ext, evt_rel});
    end
    step(1, 0, 8'h00);
    step(0, 1, 8'hAA); step(0, 1, 8'hFA);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL filter_none: valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_timeout();
    int gaps [4];
    bit ext_exp [4];
    gaps = '{20, 10, TO - 1, TO};
    ext_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'hE0);
      repeat (gaps[i]) step(0, 0, 8'h00);
      step(0, 1, 8'h1C);
      n_tests++;
      if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== {8'h1C, ext_exp[i], 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_gap%0d: got v=%b %h expected v=1 %h", gaps[i], evt_valid,
                 {evt_code, evt_ext, evt_rel}, {8'h1C, ext_exp[i], 1'b0});
      end
      step(1, 0, 8'h00);
    end
    // Pause tail abandoned by timeout: the next byte decodes normally.
    step(0, 1, 8'hE1); step(0, 1, 8'h14); step(0, 1, 8'h77);
    repeat (20) step(0, 0, 8'h00);
    step(1, 1, 8'h1C);
    n_tests++;
    if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("FAIL timeout_skip: got v=%b %h expected v=1 070", evt_valid, {evt_code, evt_ext, evt_rel});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [4];
    logic [9:0] exp [4];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    exp   = '{{8'h1D, 2'b00}, {8'h24, 2'b00}, {8'h2D, 2'b00}, {8'h12, 2'b01}};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, codes[i]);
      n_tests++;
      if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf%0d: got %b expected 0", i, evt_ovf); end
    end
    step(0, 1, 8'h12);
    n_tests++;
    if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", evt_ovf); end
    n_tests++;
    if (shift_held !== 1'b1) begin n_fail++; $display("FAIL ovf_shift: got %b expected 1", shift_held); end
    step(0, 1, 8'hF0);
    n_tests++;
    if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_once: got %b expected 0", evt_ovf); end
    step(1, 1, 8'h12);
    n_tests++;
    if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf: got %b expected 0", evt_ovf); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== exp[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: got v=%b %h expected v=1 %h", i, evt_valid, {evt_code, evt_ext, evt_rel}, exp[i]);
      end
      step(1, 0, 8'h00);
    end
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 8'h12); step(0, 1, 8'hE0);
    rst_n = 0;
    #2;
    n_tests++;
    if ({evt_valid, evt_ovf, shift_held, ctrl_held} !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_async: got %b expected 0000", {evt_valid, evt_ovf, shift_held, ctrl_held});
    end
    @(posedge clk); #1 rst_n = 1;
    model_clear();
    step(0, 1, 8'h1C);
    n_tests++;
    if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("FAIL reset_mid_prefix: got v=%b %h expected v=1 070", evt_valid, {evt_code, evt_ext, evt_rel});
    end
    drain();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 19))
      0, 1:   return 8'hE0;
      2, 3:   return 8'hF0;
      4:      return 8'hE1;
      5:      return 8'h12;
      6:      return 8'h59;
      7, 8:   return 8'h14;
      9:      return 8'hAA;
      10:     return 8'hFA;
      11:     return 8'h00;
      12:     return 8'hFF;
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic test_random();
    int idle_left;
    bit dn, rd;
    idle_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (idle_left > 0) begin idle_left--; dn = 0; end
      else begin
        dn = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 24) == 0) idle_left = $urandom_range(TO - 3, TO + 3);
      end
      rd = ($urandom_range(0, 3) == 0);
      step(rd, dn, pick_byte());
      n_tests++;
      if (evt_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && {evt_code, evt_ext, evt_rel} !== m_q[0]) ||
          evt_ovf !== m_ovf || shift_held !== (m_lsh | m_rsh) || ctrl_held !== (m_lct | m_rct)) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got v=%b h=%h o=%b s=%b c=%b expected v=%b h=%h o=%b s=%b c=%b",
                 cyc, evt_valid, {evt_code, evt_ext, evt_rel}, evt_ovf, shift_held, ctrl_held,
                 m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 10'h0, m_ovf,
                 m_lsh | m_rsh, m_lct | m_rct);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_modifiers();
    test_pause_filter();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
